// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM state encoding and latched-request type for the mem_ctrl front end.
package mem_ctrl_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    RESP
  } mem_ctrl_state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_ctrl_op_t;

endpackage

// File: rtl/mem_ctrl_stats.sv
// Saturating completed-read / completed-write counters; clear wins over a same-cycle increment.
module mem_ctrl_stats
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             incRd,
  input  logic             incWr,
  output logic [CNT_W-1:0] rdCount,
  output logic [CNT_W-1:0] wrCount
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdCount <= '0;
      wrCount <= '0;
    end else if (clr) begin
      rdCount <= '0;
      wrCount <= '0;
    end else begin
      if (incRd) rdCount <= satInc(rdCount);
      if (incWr) wrCount <= satInc(wrCount);
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Valid/ready front end that sequences the async 64x64 memory through SETUP/ACCESS/HOLD.
// Define MEM_CTRL_STATS_EN to build the saturating read/write completion counters.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              MemWr,
  output logic              MemRd,
  output logic [ADDR_W-1:0] Addr,
  inout  wire  [DATA_W-1:0] DataBus,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  if (WAIT_CYC > 7) begin : gWaitCycRange
    $error("mem_ctrl: WAIT_CYC must be in 0..7");
  end

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC);

  mem_ctrl_state_e state, stateNext;
  mem_ctrl_op_t    op;
  logic [2:0]      waitCnt;
  logic            busOe, busOeNext, memRdNext, memWrNext;
  logic            accept, lastAccess;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign lastAccess = (state == ACCESS) && (waitCnt == WAIT_LAST);
  assign Addr       = op.addr;
  assign DataBus    = busOe ? op.wdata : 'z;

  // Strobes and bus enable are computed one state ahead so they leave the flops clean.
  always_comb begin
    stateNext = state;
    memRdNext = 1'b0;
    memWrNext = 1'b0;
    busOeNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          stateNext = SETUP;
          busOeNext = req_wr;
        end
      end
      SETUP: begin
        stateNext = ACCESS;
        memRdNext = !op.wr;
        memWrNext = op.wr;
        busOeNext = op.wr;
      end
      ACCESS: begin
        busOeNext = op.wr;
        if (lastAccess) begin
          stateNext = HOLD;
        end else begin
          memRdNext = !op.wr;
          memWrNext = op.wr;
        end
      end
      HOLD:    stateNext = RESP;
      RESP:    if (resp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= '0;
      waitCnt    <= '0;
      busOe      <= 1'b0;
      MemRd      <= 1'b0;
      MemWr      <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state   <= stateNext;
      busOe   <= busOeNext;
      MemRd   <= memRdNext;
      MemWr   <= memWrNext;
      waitCnt <= (state == ACCESS && !lastAccess) ? waitCnt + 3'd1 : 3'd0;
      if (accept) op <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
      // Edge closing the last ACCESS cycle: MemRd is still high, so the bus holds read data.
      if (lastAccess) resp_rdata <= op.wr ? '0 : DataBus;
    end
  end

`ifdef MEM_CTRL_STATS_EN
  logic respDone;
  assign respDone = resp_valid && resp_ready;

  mem_ctrl_stats uStats (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (stats_clr),
    .incRd   (respDone && !op.wr),
    .incWr   (respDone && op.wr),
    .rdCount (rd_count),
    .wrCount (wr_count)
  );
`else
  logic unusedStatsClr;
  assign unusedStatsClr = stats_clr;
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a behavioural async memory on DataBus.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int W = 1;
`ifdef MEM_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, rst_n, req_valid, req_wr, resp_ready, stats_clr;
  logic [5:0]  req_addr;
  logic [63:0] req_wdata;
  logic        req_ready, resp_valid, MemWr, MemRd;
  logic [63:0] resp_rdata;
  logic [5:0]  Addr;
  wire  [63:0] DataBus;
  logic [15:0] rd_count, wr_count;

  logic [63:0] mem    [64];
  logic [63:0] refMem [64];
  logic        memInit;
  logic [63:0] expQ [$];

  int nPass = 0, nTotal = 0;
  int memWrHigh = 0, memRdHigh = 0, oeHigh = 0, rdOeClash = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl #(.WAIT_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .MemWr(MemWr), .MemRd(MemRd), .Addr(Addr), .DataBus(DataBus),
    .stats_clr(stats_clr), .rd_count(rd_count), .wr_count(wr_count)
  );

  function automatic logic [63:0] initPat(input int a);
    return 64'hC0DE_0000_0000_0000 | (64'(a) * 64'h0000_0101_0101_0101);
  endfunction

  // Behavioural async memory
  assign DataBus = MemRd ? mem[Addr] : 'z;
  always @(posedge clk) begin
    if (memInit) for (int i = 0; i < 64; i++) mem[i] <= initPat(i);
    else if (MemWr) mem[Addr] <= DataBus;
  end

  always @(negedge clk) begin
    if (MemWr) memWrHigh++;
    if (MemRd) memRdHigh++;
    if (dut.busOe) oeHigh++;
    if (dut.busOe && MemRd) rdOeClash++;
  end

  // Latency sweep instances (WAIT_CYC = 0 and 3)
  logic        sValid, lRdy0, lRv0, lRdy3, lRv3;
  wire  [63:0] unusedBus0, unusedBus3;
  logic [63:0] unusedRd0, unusedRd3;
  logic        unusedWr0, unusedRdS0, unusedWr3, unusedRdS3;
  logic [5:0]  unusedAddr0, unusedAddr3;
  logic [15:0] unusedRc0, unusedWc0, unusedRc3, unusedWc3;

  mem_ctrl #(.WAIT_CYC(0)) lat0 (
    .clk(clk), .rst_n(rst_n), .req_valid(sValid), .req_ready(lRdy0), .req_wr(1'b0),
    .req_addr(6'h3F), .req_wdata(64'd0), .resp_valid(lRv0), .resp_ready(1'b1),
    .resp_rdata(unusedRd0), .MemWr(unusedWr0), .MemRd(unusedRdS0), .Addr(unusedAddr0),
    .DataBus(unusedBus0), .stats_clr(1'b0), .rd_count(unusedRc0), .wr_count(unusedWc0)
  );

  mem_ctrl #(.WAIT_CYC(3)) lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(sValid), .req_ready(lRdy3), .req_wr(1'b0),
    .req_addr(6'h3F), .req_wdata(64'd0), .resp_valid(lRv3), .resp_ready(1'b1),
    .resp_rdata(unusedRd3), .MemWr(unusedWr3), .MemRd(unusedRdS3), .Addr(unusedAddr3),
    .DataBus(unusedBus3), .stats_clr(1'b0), .rd_count(unusedRc3), .wr_count(unusedWc3)
  );

`ifdef MEM_CTRL_STATS_EN
  logic        sClr, sIncRd, sIncWr;
  logic [15:0] sRd, sWr;
  mem_ctrl_stats satInst (
    .clk(clk), .rst_n(rst_n), .clr(sClr), .incRd(sIncRd), .incWr(sIncWr),
    .rdCount(sRd), .wrCount(sWr)
  );
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", nPass, nTotal);
    $fatal(1, "watchdog");
  end

  // One request/response through the scoreboard; lat = cycle index where resp_valid is first seen.
  task automatic doTxn(input logic wr, input logic [5:0] addr, input logic [63:0] wdata,
                       input logic clrAtResp, output int lat);
    int guard;
    int rdyBad;
    logic [63:0] exp;
    lat = -1;
    rdyBad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      nTotal++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    expQ.push_back(wr ? 64'd0 : refMem[addr]);
    if (wr) refMem[addr] = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      if (req_ready) rdyBad++;
      @(negedge clk);
      lat++;
    end
    if (req_ready) rdyBad++;
    if (!resp_valid) begin
      nTotal++;
      $display("FAIL resp_timeout: resp_valid=%0b required 1 addr=%h", resp_valid, addr);
      void'(expQ.pop_front());
      return;
    end
    exp = expQ.pop_front();
    nTotal++;
    if (resp_rdata !== exp) $display("FAIL resp_rdata addr=%h: got %h required %h", addr, resp_rdata, exp);
    else nPass++;
    stats_clr = clrAtResp;
    @(posedge clk);
    @(negedge clk);
    stats_clr = 1'b0;
    nTotal++;
    if (rdyBad != 0 || req_ready !== 1'b1)
      $display("FAIL ready_window: busy-cycles-with-ready=%0d ready-after=%0b required 0/1", rdyBad, req_ready);
    else nPass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memInit = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b1; stats_clr = 1'b0; sValid = 1'b0;
`ifdef MEM_CTRL_STATS_EN
    sClr = 1'b0; sIncRd = 1'b0; sIncWr = 1'b0;
`endif
    for (int i = 0; i < 64; i++) refMem[i] = initPat(i);
    repeat (3) @(negedge clk);
    nTotal++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b required 1", req_ready); else nPass++;
    nTotal++;
    if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b required 0", resp_valid); else nPass++;
    nTotal++;
    if ({MemRd, MemWr} !== 2'b00) $display("FAIL reset_strobes: got %b required 00", {MemRd, MemWr}); else nPass++;
    nTotal++;
    if (Addr !== 6'd0) $display("FAIL reset_addr: got %h required 00", Addr); else nPass++;
    nTotal++;
    if (resp_rdata !== 64'd0) $display("FAIL reset_rdata: got %h required 0", resp_rdata); else nPass++;
    nTotal++;
    if (dut.busOe !== 1'b0) $display("FAIL reset_bus_drive: got %b required 0", dut.busOe); else nPass++;
    nTotal++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0)
      $display("FAIL reset_counts: got rd=%0d wr=%0d required 0/0", rd_count, wr_count);
    else nPass++;
    memInit = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    nTotal++;
    if (req_ready !== 1'b1) $display("FAIL post_reset_ready: got %b required 1", req_ready); else nPass++;
  endtask

  task automatic test_latency_sweep();
    int first0, first3, bad0, bad3;
    first0 = -1; first3 = -1; bad0 = 0; bad3 = 0;
    @(negedge clk);
    sValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sValid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (lRv0 && first0 < 0) first0 = c;
      if (lRv3 && first3 < 0) first3 = c;
      if (lRdy0 !== (c >= 5)) bad0++;
      if (lRv0 !== (c == 4)) bad0++;
      if (lRdy3 !== (c >= 8)) bad3++;
      if (lRv3 !== (c == 7)) bad3++;
      @(negedge clk);
    end
    nTotal++;
    if (first0 != 4) $display("FAIL latency_w0: resp_valid at cycle %0d required 4", first0); else nPass++;
    nTotal++;
    if (first3 != 7) $display("FAIL latency_w3: resp_valid at cycle %0d required 7", first3); else nPass++;
    nTotal++;
    if (bad0 != 0) $display("FAIL handshake_shape_w0: %0d bad cycles required 0", bad0); else nPass++;
    nTotal++;
    if (bad3 != 0) $display("FAIL handshake_shape_w3: %0d bad cycles required 0", bad3); else nPass++;
  endtask

  task automatic test_write_read();
    int lat, wr0, oe0, rd0;
    resp_ready = 1'b1;
    wr0 = memWrHigh; oe0 = oeHigh;
    doTxn(1'b1, 6'h05, 64'h0123_4567_89AB_CDEF, 1'b0, lat);
    nTotal++;
    if (lat != 4 + W) $display("FAIL write_latency: got %0d required %0d", lat, 4 + W); else nPass++;
    nTotal++;
    if (memWrHigh - wr0 != W + 1)
      $display("FAIL memwr_width: got %0d cycles required %0d", memWrHigh - wr0, W + 1);
    else nPass++;
    nTotal++;
    if (oeHigh - oe0 != W + 3)
      $display("FAIL write_bus_drive: got %0d cycles required %0d", oeHigh - oe0, W + 3);
    else nPass++;
    oe0 = oeHigh; rd0 = memRdHigh;
    doTxn(1'b0, 6'h05, 64'd0, 1'b0, lat);
    nTotal++;
    if (lat != 4 + W) $display("FAIL read_latency: got %0d required %0d", lat, 4 + W); else nPass++;
    nTotal++;
    if (oeHigh - oe0 != 0) $display("FAIL read_bus_drive: got %0d cycles required 0", oeHigh - oe0); else nPass++;
    nTotal++;
    if (memRdHigh - rd0 != W + 1)
      $display("FAIL memrd_width: got %0d cycles required %0d", memRdHigh - rd0, W + 1);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] a [4];
    int lat;
    int latBad;
    latBad = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[i] = 6'($urandom_range(8, 60));
      doTxn(1'b1, a[i], {$urandom, $urandom}, 1'b0, lat);
      if (lat != 4 + W) latBad++;
    end
    for (int i = 3; i >= 0; i--) begin
      doTxn(1'b0, a[i], 64'd0, 1'b0, lat);
      if (lat != 4 + W) latBad++;
    end
    nTotal++;
    if (latBad != 0) $display("FAIL b2b_latency: %0d bad latencies required 0", latBad); else nPass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] held, exp;
    int bad, wr0, guard;
    resp_ready = 1'b0;
    wr0 = memWrHigh;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 6'h3F; req_wdata = '0;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    expQ.push_back(refMem[6'h3F]);
    @(negedge clk);
    req_wr = 1'b1; req_addr = 6'h10; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    guard = 0;
    while (!resp_valid && guard < 40) begin @(negedge clk); guard++; end
    nTotal++;
    if (resp_valid !== 1'b1) begin
      $display("FAIL bp_resp_timeout: resp_valid=%b required 1", resp_valid);
      void'(expQ.pop_front());
      req_valid = 1'b0; resp_ready = 1'b1;
      return;
    end
    nPass++;
    held = resp_rdata;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0) bad++;
    end
    nTotal++;
    if (bad != 0) $display("FAIL bp_frozen: %0d unstable cycles required 0", bad); else nPass++;
    exp = expQ.pop_front();
    nTotal++;
    if (held !== exp) $display("FAIL bp_rdata: got %h required %h", held, exp); else nPass++;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nTotal++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL bp_release: ready=%b valid=%b required 1/0", req_ready, resp_valid);
    else nPass++;
    repeat (3) @(negedge clk);
    nTotal++;
    if (memWrHigh != wr0) $display("FAIL bp_ignored_req: %0d write cycles required 0", memWrHigh - wr0);
    else nPass++;
  endtask

  task automatic test_reset_mid_access();
    int guard, bad;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 6'h02; req_wdata = 64'h5555_AAAA_5555_AAAA;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!MemWr && guard < 10) begin @(negedge clk); guard++; end
    nTotal++;
    if (MemWr !== 1'b1) $display("FAIL rst_access_reached: MemWr=%b required 1", MemWr); else nPass++;
    #2 rst_n = 1'b0;
    #1;
    nTotal++;
    if ({MemRd, MemWr} !== 2'b00) $display("FAIL rst_strobes: got %b required 00", {MemRd, MemWr}); else nPass++;
    nTotal++;
    if (dut.busOe !== 1'b0) $display("FAIL rst_bus_release: got %b required 0", dut.busOe); else nPass++;
    nTotal++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rst_handshake: valid=%b ready=%b required 0/1", resp_valid, req_ready);
    else nPass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    nTotal++;
    if (bad != 0) $display("FAIL rst_no_response: %0d bad cycles required 0", bad); else nPass++;
  endtask

  task automatic test_stats();
    int lat;
    resp_ready = 1'b1;
    doTxn(1'b1, 6'h20, 64'h1111_0000_0000_0001, 1'b0, lat);
    doTxn(1'b1, 6'h21, 64'h2222_0000_0000_0002, 1'b0, lat);
    doTxn(1'b1, 6'h22, 64'h3333_0000_0000_0003, 1'b0, lat);
    doTxn(1'b0, 6'h20, 64'd0, 1'b0, lat);
    doTxn(1'b0, 6'h22, 64'd0, 1'b0, lat);
    nTotal++;
    if (wr_count !== (STATS ? 16'd3 : 16'd0))
      $display("FAIL stats_wr: got %0d required %0d", wr_count, STATS ? 3 : 0);
    else nPass++;
    nTotal++;
    if (rd_count !== (STATS ? 16'd2 : 16'd0))
      $display("FAIL stats_rd: got %0d required %0d", rd_count, STATS ? 2 : 0);
    else nPass++;
    doTxn(1'b0, 6'h21, 64'd0, 1'b1, lat);
    nTotal++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0)
      $display("FAIL stats_clr: got rd=%0d wr=%0d required 0/0", rd_count, wr_count);
    else nPass++;
  endtask

  task automatic test_stats_saturation();
`ifdef MEM_CTRL_STATS_EN
    @(negedge clk);
    sClr = 1'b1;
    @(negedge clk);
    sClr = 1'b0; sIncRd = 1'b1; sIncWr = 1'b1;
    repeat (65535) @(negedge clk);
    nTotal++;
    if (sRd !== 16'hFFFF || sWr !== 16'hFFFF)
      $display("FAIL sat_reach: got rd=%h wr=%h required FFFF/FFFF", sRd, sWr);
    else nPass++;
    repeat (4) @(negedge clk);
    nTotal++;
    if (sRd !== 16'hFFFF || sWr !== 16'hFFFF)
      $display("FAIL sat_hold: got rd=%h wr=%h required FFFF/FFFF", sRd, sWr);
    else nPass++;
    sClr = 1'b1;
    @(negedge clk);
    sClr = 1'b0; sIncRd = 1'b0; sIncWr = 1'b0;
    nTotal++;
    if (sRd !== 16'h0 || sWr !== 16'h0)
      $display("FAIL sat_clr_priority: got rd=%h wr=%h required 0/0", sRd, sWr);
    else nPass++;
`endif
  endtask

  initial begin
    test_reset();
    test_latency_sweep();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_access();
    test_stats();
    test_stats_saturation();
    nTotal++;
    if (expQ.size() != 0) $display("FAIL scoreboard_leftover: %0d entries required 0", expQ.size());
    else nPass++;
    nTotal++;
    if (rdOeClash != 0) $display("FAIL bus_contention: %0d cycles required 0", rdOeClash); else nPass++;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
